// File: rtl/pkg_arb.sv
// Types for the two-requester memory arbiter: FSM state and requester id.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pkg_arb;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrantI = 2'd1,
    StGrantD = 2'd2
  } arb_state_e;

  typedef enum logic {
    ReqI = 1'b0,
    ReqD = 1'b1
  } req_id_e;

endpackage

// File: rtl/pkg_bool.sv
// Boolean constants shared across the arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pkg_bool;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

endpackage

// File: rtl/D_FF.sv
// Generic W-bit register with asynchronous active-low reset to RstVal.
// Latency: 1 cycle from d_i to q_o.
// Backpressure: none, loads every cycle.
//
// Ports: clk_i clock, rst_ni async reset, d_i next value, q_o registered value.
module D_FF #(
  parameter int unsigned  W      = 1,
  parameter logic [W-1:0] RstVal = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= RstVal;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache refill and dcache.
// Latency: grant 1 cycle after request seen idle; ready/rdata/addr paths combinational.
// Backpressure: grant held until mem_ready_i or watchdog timeout; loser waits at level.
//
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   ic_req_i/ic_addr_i                icache refill request and address
//   ic_rdata_o/ic_ready_o             icache read data and completion pulse
//   dc_req_i/dc_we_i/dc_addr_i/dc_wdata_i  dcache request, write enable, address, data
//   dc_rdata_o/dc_ready_o             dcache read data and completion pulse
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request side
//   mem_rdata_i/mem_ready_i           memory response side
//   err_o                             sticky watchdog-timeout flag
module mem_arbiter
  import pkg_arb::*;
  import pkg_bool::*;
#(
  parameter int unsigned DWidth        = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_i,
  input  logic [DWidth-1:0] ic_addr_i,
  output logic [DWidth-1:0] ic_rdata_o,
  output logic              ic_ready_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [DWidth-1:0] dc_addr_i,
  input  logic [DWidth-1:0] dc_wdata_i,
  output logic [DWidth-1:0] dc_rdata_o,
  output logic              dc_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DWidth-1:0] mem_addr_o,
  output logic [DWidth-1:0] mem_wdata_o,
  input  logic [DWidth-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              err_o
);

  // Counter holds 0..TimeoutCycles-1; value k-1 on the k-th granted cycle.
  localparam int unsigned    CntW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [1:0]  state_raw;
  logic        ptr_raw;
  arb_state_e  state_q, state_d;
  req_id_e     ptr_q, ptr_d;
  logic        err_q, err_d;
  logic [CntW-1:0] cnt_q;

  logic granted;
  logic timeout;
  logic done;
  logic entering_grant;

  // ---------------------------------------------------------------- state regs
  D_FF #(.W(2), .RstVal(2'(StIdle))) u_state_ff (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (state_d),
    .q_o    (state_raw)
  );

  D_FF #(.W(1), .RstVal(1'(ReqI))) u_ptr_ff (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ptr_d),
    .q_o    (ptr_raw)
  );

  D_FF #(.W(1), .RstVal(False)) u_err_ff (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (err_d),
    .q_o    (err_q)
  );

  assign state_q = arb_state_e'(state_raw);
  assign ptr_q   = req_id_e'(ptr_raw);

  // Watchdog fires only when the memory has not answered on the last allowed cycle,
  // so a ready arriving on that same cycle is still a clean completion.
  assign granted = (state_q != StIdle);
  assign timeout = granted && !mem_ready_i && (cnt_q == CntLast);
  assign done    = granted && (mem_ready_i || timeout);

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (ic_req_i && dc_req_i) begin
          state_d = (ptr_q == ReqI) ? StGrantI : StGrantD;
        end else if (ic_req_i) begin
          state_d = StGrantI;
        end else if (dc_req_i) begin
          state_d = StGrantD;
        end
      end
      // On completion the owner's request is still high while it consumes ready,
      // so only the other requester is considered for the immediate hand-over.
      StGrantI: begin
        if (done) begin
          ptr_d   = ReqD;
          state_d = dc_req_i ? StGrantD : StIdle;
        end
      end
      StGrantD: begin
        if (done) begin
          ptr_d   = ReqI;
          state_d = ic_req_i ? StGrantI : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign err_d = err_q | timeout;

  // ---------------------------------------------------------------- watchdog
  assign entering_grant = (state_d != StIdle) && ((state_q == StIdle) || done);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (entering_grant) begin
      cnt_q <= '0;
    end else if (granted && !done) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    mem_req_o   = False;
    mem_we_o    = False;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    ic_ready_o  = False;
    dc_ready_o  = False;
    ic_rdata_o  = mem_rdata_i;
    dc_rdata_o  = mem_rdata_i;
    unique case (state_q)
      StGrantI: begin
        mem_req_o  = True;
        mem_addr_o = ic_addr_i;
        ic_ready_o = mem_ready_i | timeout;
        if (timeout) ic_rdata_o = '0;
      end
      StGrantD: begin
        mem_req_o   = True;
        mem_we_o    = dc_we_i;
        mem_addr_o  = dc_addr_i;
        mem_wdata_o = dc_wdata_i;
        dc_ready_o  = mem_ready_i | timeout;
        if (timeout) dc_rdata_o = '0;
      end
      default: ;
    endcase
  end

  assign err_o = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported main-memory port between the instruction-cache refill path and the data-cache path. Grants are round-robin and held until the memory returns `mem_ready_i`. A watchdog terminates stalled transfers. The block sits between both caches and the memory controller, and forwards address, write data and handshakes combinationally for the granted requester.

## Interface
Parameters:
- `DWidth`, 32, address/data width
- `TimeoutCycles`, 255, maximum granted cycles without `mem_ready_i` before forced completion (≥2)

Ports:
- `clk_i` in 1, clock
- `rst_ni` in 1, asynchronous active-low reset
- `ic_req_i` in 1, icache refill request (level, held until ready)
- `ic_addr_i` in DWidth, icache refill address
- `ic_rdata_o` out DWidth, read data to icache
- `ic_ready_o` out 1, icache transfer complete (1-cycle pulse)
- `dc_req_i` in 1, dcache request (level, held until ready)
- `dc_we_i` in 1, dcache write enable
- `dc_addr_i` in DWidth, dcache address
- `dc_wdata_i` in DWidth, dcache write data
- `dc_rdata_o` out DWidth, read data to dcache
- `dc_ready_o` out 1, dcache transfer complete (1-cycle pulse)
- `mem_req_o` out 1, memory request
- `mem_we_o` out 1, memory write enable
- `mem_addr_o` out DWidth, memory address
- `mem_wdata_o` out DWidth, memory write data
- `mem_rdata_i` in DWidth, memory read data
- `mem_ready_i` in 1, memory transfer complete
- `err_o` out 1, sticky timeout flag

## Operation
- FSM states: `StIdle`, `StGrantI`, `StGrantD`.
- Reset: state `StIdle`, priority pointer set to icache, timeout counter 0, `err_o` 0.
- In `StIdle`:
  - One request pending: grant it.
  - Both pending: grant the requester the pointer selects.
  - No request: stay in `StIdle`.
  - Grant takes effect next cycle.
- In `StGrantI`:
  - `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=`ic_addr_i`, `mem_wdata_o`='0.
- In `StGrantD`:
  - `mem_req_o`=1, `mem_we_o`=`dc_we_i`, `mem_addr_o`=`dc_addr_i`, `mem_wdata_o`=`dc_wdata_i`.
- In `StIdle`, all `mem_*` outputs are 0.
- `ic_rdata_o` and `dc_rdata_o` both carry `mem_rdata_i` unconditionally, except when timeout forces them to '0.
- `ic_ready_o`/`dc_ready_o` = `mem_ready_i` gated by the matching grant state. A non-granted requester never sees ready.
- Completion (`mem_ready_i`=1 while granted):
  - The pointer moves to the other requester.
  - The granted requester's request is ignored for this cycle's arbitration, because it is still high while it consumes ready.
  - Next state is the other grant state if the other requester's request is high, else `StIdle`.
- Timeout counter:
  - Clears on entry to a grant state.
  - Increments each granted cycle without `mem_ready_i`.
- Forced completion: when the counter equals `TimeoutCycles-1` and `mem_ready_i`=0:
  - Assert the granted requester's ready.
  - Drive that requester's rdata to '0.
  - Set `err_o`.
  - Transition exactly as on normal completion.
- `err_o` clears only on reset.
- `mem_ready_i` in `StIdle` is ignored.
- Dropping a request while granted is a protocol violation. The arbiter keeps the grant until ready or timeout.

## Timing
- Grant latency: 1 cycle from request, seen in `StIdle`, to `mem_req_o`.
- Ready path `mem_ready_i` → `*_ready_o` is combinational, zero-cycle.
- Back-to-back different requesters: the second grant is active the cycle after the first completes, with no idle bubble.
- Same requester re-requesting alone: one `StIdle` cycle between grants.
- Async reset mid-transfer:
  - `mem_req_o` and ready outputs drop immediately.
  - The in-flight transfer is abandoned.
  - After reset, the pointer is back on icache.
- Timeout fires on granted cycle `TimeoutCycles`, counting the first granted cycle as 1.

## Structure
- `pkg_arb` holds the `arb_state_e` typedef (2-bit) and the requester id enum (`ReqI`, `ReqD`).
- Booleans come from `pkg_bool`.
- State, pointer and `err_o` registers use `D_FF` instances.
- The timeout counter is a dedicated clearable counter, implemented inline.
- No further sub-modules.

## Test plan
- **Single icache miss:** `ic_req_i`=1, addr 0x100; memory asserts ready 3 cycles after `mem_req_o` with rdata 0xDEADBEEF → `mem_addr_o`=0x100 from cycle 1, `ic_ready_o` pulses one cycle with `ic_rdata_o`=0xDEADBEEF, `dc_ready_o` stays 0.
- **Simultaneous requests after reset:** both requests raised together → icache granted first. On its ready, `StGrantD` next cycle with `mem_we_o`=`dc_we_i`. Repeat with both again → icache served first, because the pointer alternates.
- **Back-to-back dcache writes:** addr 0x40, wdata 0x12345678, icache idle → `mem_we_o`=1 and `mem_wdata_o`=0x12345678 while granted. One `StIdle` cycle between consecutive writes.
- **Timeout:** `TimeoutCycles`=4, dcache granted, `mem_ready_i` held 0 → `dc_ready_o`=1 with `dc_rdata_o`=0 on granted cycle 4. `err_o`=1 and stays 1. A subsequent icache request is then served normally.
- **Reset mid-transfer:** `rst_ni` pulled low during `StGrantI` → `mem_req_o`=0 asynchronously. After release with `dc_req_i`=1 only, the dcache is granted one cycle later.
